// File: rtl/mul_cell_arbiter.sv
// -----------------------------------------------------------------------------
// mul_cell_arbiter
//
// Shares one external 16x16 three-partial-product multiplier cell between two
// requesters. Requests are arbitrated round-robin, the operands are driven
// onto the cell for one enabled cycle, and the partial products are
// recombined into the low 32 bits of a*b. One registered result goes back to
// the granted requester over a valid/ready handshake.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   reqN_valid/ready         request handshake (N = 0, 1)
//   reqN_a, reqN_b           32-bit unsigned operands
//   rspN_valid/ready         response handshake (N = 0, 1)
//   rsp_result               low 32 bits of a*b, shared by both responders
//   cell_src1, cell_src2     operands driven to the multiplier cell
//   cell_en                  multiplier cell register enable
//   cell_p1, cell_p2, cell_p3  partial products a_lo*b_lo, a_lo*b_hi, a_hi*b_lo
//   busy                     high whenever the FSM is not idle
//   done_count               completed responses, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mul_cell_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_result,

    output logic [31:0]      cell_src1,
    output logic [31:0]      cell_src2,
    output logic             cell_en,
    input  logic [31:0]      cell_p1,
    input  logic [31:0]      cell_p2,
    input  logic [31:0]      cell_p3,

    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic             last_q;      // id of the requester served most recently
    logic             id_q;        // id of the operation in flight
    logic [31:0]      op_a_q;
    logic [31:0]      op_b_q;
    logic [31:0]      result_q;
    logic [CNT_W-1:0] done_count_q;

    logic             gnt_valid;
    logic             gnt_id;
    logic             accept;
    logic             rsp_take;
    logic [31:0]      gnt_a;
    logic [31:0]      gnt_b;
    logic [15:0]      cross_sum;
    logic [31:0]      result_d;

    // Only the low halves of the cross products land inside the 32-bit result.
    logic unused_hi;
    assign unused_hi = ^{cell_p2[31:16], cell_p3[31:16]};

    // ------------------------------------------------------------------
    // Round-robin grant: a lone requester wins; on a tie the requester
    // that was not served last wins.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_q;
        end else begin
            gnt_id = req1_valid;
        end
    end

    assign gnt_a    = gnt_id ? req1_a : req0_a;
    assign gnt_b    = gnt_id ? req1_b : req0_b;
    assign accept   = (state_q == IDLE) && gnt_valid;
    assign rsp_take = (state_q == RESP) && (id_q ? rsp1_ready : rsp0_ready);

    // a*b mod 2^32 = p1 + ((p2 + p3) << 16); the carry out of the 16-bit
    // cross sum would land above bit 31, so it is dropped on purpose.
    assign cross_sum = cell_p2[15:0] + cell_p3[15:0];
    assign result_d  = cell_p1 + {cross_sum, 16'h0000};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        cell_en    = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                req0_ready = gnt_valid && !gnt_id;
                req1_ready = gnt_valid &&  gnt_id;
            end
            ISSUE: begin
                cell_en = 1'b1;
            end
            RESP: begin
                rsp0_valid = !id_q;
                rsp1_valid =  id_q;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            done_count_q <= '0;
        end else begin
            if (accept) begin
                op_a_q <= gnt_a;
                op_b_q <= gnt_b;
                id_q   <= gnt_id;
                last_q <= gnt_id;
            end
            if (state_q == CAPTURE) begin
                result_q <= result_d;
            end
            if (rsp_take) begin
                done_count_q <= done_count_q + 1'b1;
            end
        end
    end

    // The cell operands come straight from the op registers, so they are
    // already stable for the whole ISSUE cycle.
    assign cell_src1  = op_a_q;
    assign cell_src2  = op_b_q;
    assign rsp_result = result_q;
    assign done_count = done_count_q;

endmodule
